// File: rtl/uart_pkg.sv
// Shared definitions for uart_param: parity encodings, frame FSM states and the parity helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Payload is zero-extended to 9 bits; the padding does not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] par);
        return (par == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable modulo-CLK_DIV counter with wrap, mid-bit and one-before-wrap ticks.
module uart_baud_tick #(
    parameter int CLK_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick,
    output logic half_tick,
    output logic pre_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart || cnt_q == LAST) cnt_d = '0;
        else                          cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick      = (cnt_q == LAST);
    assign half_tick = (cnt_q == HALF);
    assign pre_tick  = (cnt_q == PRE);

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART (DATA_BITS, PARITY, STOP_BITS) with valid/ready TX and flagged RX.
// Optional UART_LOOPBACK_EN adds a loopback input routing the registered tx into the receiver.
module uart_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [1:0]    PAR       = 2'(PARITY);

    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_word_q, tx_word_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_q, tx_d, tx_ready_q, tx_ready_d;
    logic                 tx_restart, tx_tick, tx_pre_tick, tx_half_unused, tx_accept;

    uart_state_e          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_word_q, rx_word_d, rx_data_q, rx_data_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic                 rx_par_q, rx_par_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q, rx_in, rx_fall;
    logic                 rx_restart, rx_half, rx_tick_unused, rx_pre_unused;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tx_baud (
        .clk(clk), .rst(rst), .restart(tx_restart),
        .tick(tx_tick), .half_tick(tx_half_unused), .pre_tick(tx_pre_tick)
    );

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_rx_baud (
        .clk(clk), .rst(rst), .restart(rx_restart),
        .tick(rx_tick_unused), .half_tick(rx_half), .pre_tick(rx_pre_unused)
    );

    assign tx_accept = tx_valid && tx_ready_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_word_d  = tx_word_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        tx_restart = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_accept) begin
                    tx_word_d  = tx_data;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                    tx_restart = 1'b1;
                    tx_state_d = ST_START;
                end
            end
            ST_START: if (tx_tick) begin
                tx_d       = tx_word_q[0];
                tx_bit_d   = '0;
                tx_state_d = ST_DATA;
            end
            ST_DATA: if (tx_tick) begin
                if (tx_bit_q == LAST_BIT) begin
                    tx_bit_d = '0;
                    if (PAR != PAR_NONE) begin
                        tx_d       = parity_bit(9'(tx_word_q), PAR);
                        tx_state_d = ST_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
                    end
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_d     = tx_word_q[tx_bit_q + 1'b1];
                end
            end
            ST_PARITY: if (tx_tick) begin
                tx_d       = 1'b1;
                tx_state_d = ST_STOP;
            end
            ST_STOP: begin
                // Ready is raised one cycle early so a word can chain onto the final stop edge.
                if (tx_pre_tick && tx_bit_q == LAST_STOP) tx_ready_d = 1'b1;
                if (tx_tick) begin
                    if (tx_bit_q != LAST_STOP) begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end else if (tx_accept) begin
                        tx_word_d  = tx_data;
                        tx_d       = 1'b0;
                        tx_ready_d = 1'b0;
                        tx_restart = 1'b1;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_word_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_word_q  <= tx_word_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : rx;
    assign tx    = loopback ? 1'b1 : tx_q;
`else
    assign rx_in = rx;
    assign tx    = tx_q;
`endif

    assign rx_fall = rx_prev_q && !rx_sync_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_word_d  = rx_word_q;
        rx_bit_d   = rx_bit_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
        rx_restart = 1'b0;
        case (rx_state_q)
            ST_IDLE: if (rx_fall) begin
                rx_restart = 1'b1;
                rx_state_d = ST_START;
            end
            ST_START: if (rx_half) begin
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_half) begin
                rx_word_d[rx_bit_q] = rx_sync_q;
                if (rx_bit_q == LAST_BIT) rx_state_d = (PAR != PAR_NONE) ? ST_PARITY : ST_STOP;
                else                      rx_bit_d   = rx_bit_q + 1'b1;
            end
            ST_PARITY: if (rx_half) begin
                rx_par_d   = rx_sync_q;
                rx_state_d = ST_STOP;
            end
            ST_STOP: if (rx_half) begin
                rx_data_d  = rx_word_q;
                rx_perr_d  = (PAR != PAR_NONE) && (rx_par_q != parity_bit(9'(rx_word_q), PAR));
                rx_ferr_d  = !rx_sync_q;
                rx_valid_d = 1'b1;
                rx_state_d = ST_IDLE;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_word_q  <= '0;
            rx_bit_q   <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_word_q  <= rx_word_d;
            rx_bit_q   <= rx_bit_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready      = tx_ready_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: an 8N1 instance and a 7E2 instance, both at CLK_DIV=4.
module tb_uart_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lb8 = 1'b0;
    logic       lb7 = 1'b0;

    logic       rx8 = 1'b1, tx8, txv8 = 1'b0, txr8, rxv8, pe8, fe8;
    logic [7:0] txd8 = '0, rxd8;
    logic       rx7 = 1'b1, tx7, txv7 = 1'b0, txr7, rxv7, pe7, fe7;
    logic [6:0] txd7 = '0, rxd7;

    int ncmp = 0;
    int nfail = 0;
    int nv8 = 0, nv7 = 0;
    logic [7:0] cap8 = '0;
    logic [6:0] cap7 = '0;
    logic       cpe8 = 1'b0, cfe8 = 1'b0, cpe7 = 1'b0, cfe7 = 1'b0;

    always #5 clk = ~clk;

    uart_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8 (
        .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
        .loopback(lb8),
`endif
        .rx(rx8), .tx(tx8), .tx_data(txd8), .tx_valid(txv8), .tx_ready(txr8),
        .rx_data(rxd8), .rx_valid(rxv8), .rx_parity_err(pe8), .rx_frame_err(fe8)
    );

    uart_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u7 (
        .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
        .loopback(lb7),
`endif
        .rx(rx7), .tx(tx7), .tx_data(txd7), .tx_valid(txv7), .tx_ready(txr7),
        .rx_data(rxd7), .rx_valid(rxv7), .rx_parity_err(pe7), .rx_frame_err(fe7)
    );

    // Records every cycle rx_valid is high, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (rxv8) begin
            nv8++;
            cap8 = rxd8;
            cpe8 = pe8;
            cfe8 = fe8;
        end
        if (rxv7) begin
            nv7++;
            cap7 = rxd7;
            cpe7 = pe7;
            cfe7 = fe7;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame, LSB first, 4 clocks per bit, onto rx8 (sel=8) or rx7.
    task automatic send_rx(input int sel, input logic [15:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 8) rx8 = frame[i];
            else          rx7 = frame[i];
            cyc(4);
        end
        rx8 = 1'b1;
        rx7 = 1'b1;
    endtask

    initial begin
        logic [15:0] f;
        logic [19:0] fb;

        cyc(3);
        check("rst_tx8", 16'(tx8), 16'h1);
        check("rst_ready8", 16'(txr8), 16'h1);
        check("rst_rxdata8", 16'(rxd8), 16'h0);
        check("rst_rxvalid8", 16'(rxv8), 16'h0);
        check("rst_perr8", 16'(pe8), 16'h0);
        check("rst_ferr8", 16'(fe8), 16'h0);
        check("rst_tx7", 16'(tx7), 16'h1);
        check("rst_rxdata7", 16'(rxd7), 16'h0);
        rst = 1'b0;
        cyc(3);

        // 8N1 transmit of 0xA5
        f = 16'({1'b1, 8'hA5, 1'b0});
        txd8 = 8'hA5;
        txv8 = 1'b1;
        check("a5_ready_pre", 16'(txr8), 16'h1);
        @(negedge clk);
        txv8 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            check("a5_tx", 16'(tx8), 16'(f[(k - 1) / 4]));
            check("a5_ready", 16'(txr8), 16'(k == 40));
            @(negedge clk);
        end
        check("a5_idle_tx", 16'(tx8), 16'h1);
        check("a5_idle_ready", 16'(txr8), 16'h1);

        // back-to-back 0x00 then 0xFF with tx_valid held
        fb = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        txd8 = 8'h00;
        txv8 = 1'b1;
        @(negedge clk);
        txd8 = 8'hFF;
        for (int k = 1; k <= 80; k++) begin
            check("b2b_tx", 16'(tx8), 16'(fb[(k - 1) / 4]));
            check("b2b_ready", 16'(txr8), 16'(k == 40 || k == 80));
            if (k == 41) txv8 = 1'b0;
            @(negedge clk);
        end
        check("b2b_idle_tx", 16'(tx8), 16'h1);

        // reset in the middle of data bit 3
        txd8 = 8'h00;
        txv8 = 1'b1;
        @(negedge clk);
        txv8 = 1'b0;
        cyc(17);
        check("mid_tx_low", 16'(tx8), 16'h0);
        check("mid_ready_low", 16'(txr8), 16'h0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_tx", 16'(tx8), 16'h1);
        check("async_rst_ready", 16'(txr8), 16'h1);
        @(negedge clk);
        rst = 1'b0;
        cyc(6);
        check("post_rst_tx", 16'(tx8), 16'h1);

        // RX 0x3C with stop bit low
        send_rx(8, 16'({1'b0, 8'h3C, 1'b0}), 10);
        cyc(10);
        check("ferr_count", 16'(nv8), 16'd1);
        check("ferr_data", 16'(cap8), 16'h3C);
        check("ferr_flag", 16'(cfe8), 16'h1);
        check("ferr_perr", 16'(cpe8), 16'h0);

        // false start, then a clean 0x81
        rx8 = 1'b0;
        @(negedge clk);
        rx8 = 1'b1;
        cyc(12);
        check("false_start", 16'(nv8), 16'd1);
        send_rx(8, 16'({1'b1, 8'h81, 1'b0}), 10);
        cyc(10);
        check("rx81_count", 16'(nv8), 16'd2);
        check("rx81_data", 16'(cap8), 16'h81);
        check("rx81_ferr", 16'(cfe8), 16'h0);
        check("rx81_hold", 16'(rxd8), 16'h81);
        check("rx81_valid_low", 16'(rxv8), 16'h0);

        // 7E2: payload 0x55 (four ones, even parity bit 0) sent with parity 1
        send_rx(7, 16'({1'b1, 1'b1, 1'b1, 7'h55, 1'b0}), 11);
        cyc(10);
        check("perr_count", 16'(nv7), 16'd1);
        check("perr_data", 16'(cap7), 16'h55);
        check("perr_flag", 16'(cpe7), 16'h1);
        check("perr_ferr", 16'(cfe7), 16'h0);
        send_rx(7, 16'({1'b1, 1'b1, 1'b0, 7'h55, 1'b0}), 11);
        cyc(10);
        check("par55_ok", 16'(cpe7), 16'h0);
        send_rx(7, 16'({1'b1, 1'b1, 1'b1, 7'h07, 1'b0}), 11);
        cyc(10);
        check("par07_count", 16'(nv7), 16'd3);
        check("par07_data", 16'(cap7), 16'h07);
        check("par07_ok", 16'(cpe7), 16'h0);

        // 7E2 transmit of 0x55: start, 1010101, parity 0, two stops
        f = 16'({1'b1, 1'b1, 1'b0, 7'h55, 1'b0});
        txd7 = 7'h55;
        txv7 = 1'b1;
        @(negedge clk);
        txv7 = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            if (k % 4 == 2) check("tx7_bit", 16'(tx7), 16'(f[(k - 1) / 4]));
            if (k >= 40) check("tx7_ready", 16'(txr7), 16'(k == 44));
            @(negedge clk);
        end

`ifdef UART_LOOPBACK_EN
        lb8 = 1'b1;
        cyc(4);
        txd8 = 8'h5A;
        txv8 = 1'b1;
        @(negedge clk);
        txv8 = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            if (k % 4 == 0) check("lb_tx_pin", 16'(tx8), 16'h1);
            @(negedge clk);
        end
        cyc(6);
        check("lb_count", 16'(nv8), 16'd3);
        check("lb_data", 16'(cap8), 16'h5A);
        lb8 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
